// File: rtl/hamming_pkg.sv
// Shared constants and types for the serial SECDED Hamming(8,4) decoder.
// Codeword positions are numbered 1..8 in wire order; position 1 lands in the word MSB.
package hamming_pkg;

    localparam int CW_W   = 8;
    localparam int DATA_W = 4;

    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_D1 = 3;
    localparam int POS_P4 = 4;
    localparam int POS_D2 = 5;
    localparam int POS_D3 = 6;
    localparam int POS_D4 = 7;
    localparam int POS_P8 = 8;

    // Bit index inside the assembled word for each codeword position
    localparam int IDX_P1 = CW_W - POS_P1;
    localparam int IDX_P2 = CW_W - POS_P2;
    localparam int IDX_D1 = CW_W - POS_D1;
    localparam int IDX_P4 = CW_W - POS_P4;
    localparam int IDX_D2 = CW_W - POS_D2;
    localparam int IDX_D3 = CW_W - POS_D3;
    localparam int IDX_D4 = CW_W - POS_D4;
    localparam int IDX_P8 = CW_W - POS_P8;

    typedef logic [2:0] syndrome_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SINGLE,
        ERR_DOUBLE
    } err_kind_t;

endpackage

// File: rtl/hamming_secded_check.sv
// Combinational SECDED check: syndrome, overall parity, single-bit correction
// and data extraction for one Hamming(8,4) codeword.
module hamming_secded_check
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]   word,
    output syndrome_t         syndrome,
    output err_kind_t         err_kind,
    output logic [DATA_W-1:0] data
);

    logic            s1, s2, s4, par;
    logic [CW_W-1:0] flip;
    logic [CW_W-1:0] fixed;

    always_comb begin
        s1  = word[IDX_P1] ^ word[IDX_D1] ^ word[IDX_D2] ^ word[IDX_D4];
        s2  = word[IDX_P2] ^ word[IDX_D1] ^ word[IDX_D3] ^ word[IDX_D4];
        s4  = word[IDX_P4] ^ word[IDX_D2] ^ word[IDX_D3] ^ word[IDX_D4];
        par = (^word[CW_W-1:1]) ^ word[IDX_P8];
        syndrome = {s4, s2, s1};

        // Position S sits at bit CW_W-S, i.e. MSB shifted right by S-1
        flip = '0;
        if ((syndrome != 3'd0) && par)
            flip = 8'h80 >> (syndrome - 3'd1);
        fixed = word ^ flip;

        if (!par && (syndrome == 3'd0))
            err_kind = ERR_NONE;
        else if (par)
            err_kind = ERR_SINGLE;
        else
            err_kind = ERR_DOUBLE;

        data = {fixed[IDX_D1], fixed[IDX_D2], fixed[IDX_D3], fixed[IDX_D4]};
    end

endmodule

// File: rtl/hamming_serial_decoder.sv
// Serial SECDED Hamming(8,4) decoder: shifts in 8-bit codewords, corrects/flags
// errors, and shifts the 4 data bits out with double-buffered receive/transmit.
module hamming_serial_decoder
    import hamming_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      serial_in,
    input  logic      write,
    output logic      serial_out,
    output logic      out_valid,
    output logic      err_single,
    output logic      err_double,
    output syndrome_t syndrome
);

    localparam logic [2:0] RX_LAST = 3'(CW_W - 1);

    // Handshake: write is a valid-only qualifier (no ready); every write=1 cycle
    // consumes one bit, and out_valid marks each data bit with no back-pressure.
    logic [2:0]        rx_cnt;
    logic [CW_W-2:0]   rx_sr;
    logic [CW_W-1:0]   cw_hold;
    logic              cw_rdy;
    logic [DATA_W-1:0] tx_sr;
    logic [2:0]        tx_left;

    syndrome_t         chk_syndrome;
    err_kind_t         chk_kind;
    logic [DATA_W-1:0] chk_data;

    hamming_secded_check u_check (
        .word     (cw_hold),
        .syndrome (chk_syndrome),
        .err_kind (chk_kind),
        .data     (chk_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt  <= '0;
            rx_sr   <= '0;
            cw_hold <= '0;
            cw_rdy  <= 1'b0;
        end else begin
            cw_rdy <= write && (rx_cnt == RX_LAST);
            if (write) begin
                rx_sr <= {rx_sr[CW_W-3:0], serial_in};
                if (rx_cnt == RX_LAST) begin
                    cw_hold <= {rx_sr, serial_in};
                    rx_cnt  <= '0;
                end else begin
                    rx_cnt <= rx_cnt + 3'd1;
                end
            end
        end
    end

    // tx_left counts bits still to present, including the one on serial_out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr      <= '0;
            tx_left    <= '0;
            err_single <= 1'b0;
            err_double <= 1'b0;
            syndrome   <= '0;
        end else if (cw_rdy) begin
            tx_sr      <= chk_data;
            tx_left    <= 3'(DATA_W);
            err_single <= (chk_kind == ERR_SINGLE);
            err_double <= (chk_kind == ERR_DOUBLE);
            syndrome   <= chk_syndrome;
        end else if (tx_left != 3'd0) begin
            tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
            tx_left <= tx_left - 3'd1;
        end
    end

    assign out_valid  = (tx_left != 3'd0);
    assign serial_out = out_valid & tx_sr[DATA_W-1];

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// Directed bench for hamming_serial_decoder: hand-computed codewords, immediate
// assertions at each comparison point, one summary line at the end.
module tb_hamming_serial_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       write;
    logic       serial_out;
    logic       out_valid;
    logic       err_single;
    logic       err_double;
    logic [2:0] syndrome;

    int vectors     = 0;
    int miscompares = 0;

    // clock / reset block
    always #5 clk = ~clk;

    hamming_serial_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .write      (write),
        .serial_out (serial_out),
        .out_valid  (out_valid),
        .err_single (err_single),
        .err_double (err_double),
        .syndrome   (syndrome)
    );

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: present one input cycle at the negedge, return after the next negedge
    task automatic drive(input logic w, input logic b);
        write     = w;
        serial_in = b;
        @(negedge clk);
    endtask

    // codeword MSB is position 1 (sent first)
    task automatic send_word(input logic [7:0] cw);
        for (int i = 7; i >= 0; i--) drive(1'b1, cw[i]);
        write     = 1'b0;
        serial_in = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, {7'd0, out_valid}, 8'd0);
        chk({tag, "_sout"},  {7'd0, serial_out}, 8'd0);
        chk({tag, "_es"},    {7'd0, err_single}, 8'd0);
        chk({tag, "_ed"},    {7'd0, err_double}, 8'd0);
        chk({tag, "_syn"},   {5'd0, syndrome},   8'd0);
    endtask

    // scoreboard for one 4-cycle burst starting one edge after the 8th bit
    task automatic check_burst(input string tag, input logic [3:0] data, input logic [2:0] syn,
                               input logic es, input logic ed);
        logic [7:0] exp_q[$];
        for (int i = 3; i >= 0; i--) exp_q.push_back({7'd0, data[i]});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
            chk({tag, "_bit"},   {7'd0, serial_out}, exp_q.pop_front());
            chk({tag, "_syn"},   {5'd0, syndrome},   {5'd0, syn});
            chk({tag, "_es"},    {7'd0, err_single}, {7'd0, es});
            chk({tag, "_ed"},    {7'd0, err_double}, {7'd0, ed});
        end
        @(negedge clk);
        chk({tag, "_end_valid"}, {7'd0, out_valid}, 8'd0);
        chk({tag, "_end_sout"},  {7'd0, serial_out}, 8'd0);
        chk({tag, "_hold_syn"},  {5'd0, syndrome},   {5'd0, syn});
        chk({tag, "_hold_es"},   {7'd0, err_single}, {7'd0, es});
        chk({tag, "_hold_ed"},   {7'd0, err_double}, {7'd0, ed});
    endtask

    logic [15:0] pair;
    logic        ov_log [0:21];
    logic        so_log [0:21];
    logic        exp_ov;
    logic        exp_so;
    logic [3:0]  exp_d;

    initial begin
        rst       = 1'b1;
        write     = 1'b0;
        serial_in = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        // clean word: data 1011
        send_word(8'b0110_0110);
        chk("clean_cwrdy_gap", {7'd0, out_valid}, 8'd0);
        check_burst("clean", 4'b1011, 3'd0, 1'b0, 1'b0);

        // single error at position 5
        send_word(8'b0110_1110);
        check_burst("single5", 4'b1011, 3'd5, 1'b1, 1'b0);

        // double error at positions 2 and 6: data left uncorrected
        send_word(8'b0010_0010);
        check_burst("double26", 4'b1001, 3'd4, 1'b0, 1'b1);

        // p8 in error
        send_word(8'b0110_0111);
        check_burst("p8", 4'b1011, 3'd0, 1'b1, 1'b0);

        // gapped clean word: idle cycles with junk on serial_in between bits
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] cw;
            cw = 8'b0110_0110;
            if (i != 7) begin
                repeat ($urandom_range(1, 3)) drive(1'b0, 1'($urandom_range(0, 1)));
            end
            drive(1'b1, cw[i]);
        end
        write = 1'b0;
        check_burst("gapped", 4'b1011, 3'd0, 1'b0, 1'b0);

        // back-to-back: data 1011 then data 0101 (codeword 0100_1011), no gaps
        pair = {8'b0110_0110, 8'b0100_1011};
        for (int c = 0; c < 22; c++) begin
            drive(c < 16, (c < 16) ? pair[15 - c] : 1'b0);
            ov_log[c] = out_valid;
            so_log[c] = serial_out;
        end
        for (int c = 0; c < 22; c++) begin
            exp_ov = ((c >= 8) && (c <= 11)) || ((c >= 16) && (c <= 19));
            exp_d  = (c < 16) ? 4'b1011 : 4'b0101;
            exp_so = 1'b0;
            if (c >= 8 && c <= 11)  exp_so = exp_d[11 - c];
            if (c >= 16 && c <= 19) exp_so = exp_d[19 - c];
            chk($sformatf("b2b_valid_%0d", c), {7'd0, ov_log[c]}, {7'd0, exp_ov});
            chk($sformatf("b2b_bit_%0d", c),   {7'd0, so_log[c]}, {7'd0, exp_so});
        end

        // reset mid-word: 5 bits of a word with corrupted data, then reset
        for (int i = 7; i >= 3; i--) begin
            logic [7:0] cw;
            cw = 8'b1111_1111;
            drive(1'b1, cw[i]);
        end
        write = 1'b0;
        rst   = 1'b1;
        #1;
        chk_idle_outputs("midrst_async");
        @(negedge clk);
        chk_idle_outputs("midrst_held");
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midrst_release");
        send_word(8'b0110_0110);
        chk_idle_outputs("midrst_before_decode");
        check_burst("midrst_clean", 4'b1011, 3'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
